// File: rtl/haz_pkg.sv
// Shared types, channel indices and default timing constants for the hazard sensor front-end.
package haz_pkg;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } ch_state_e;

  localparam int CH_GAS   = 0;
  localparam int CH_SMOKE = 1;
  localparam int CH_HUM   = 2;
  localparam int CH_TEMP  = 3;
  localparam int NUM_CH   = 4;

  localparam int DEF_DEB_CYCLES = 4;
  localparam int DEF_SAMPLE_DIV = 1;

  // Debounce counter must be able to hold the value DEB_CYCLES itself.
  function automatic int cnt_width(input int deb);
    return $clog2(deb + 1);
  endfunction

endpackage

// File: rtl/hazard_debounce_ch.sv
// One sensor channel: 2-flop synchroniser feeding a tick-driven STABLE/PENDING debounce FSM.
// With HAZ_LATCH_EN defined, a channel whose latch_i is 1 holds a debounced 1 until clr_i.
module hazard_debounce_ch
  import haz_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  input  logic en_i,
  input  logic tick_i,
  input  logic latch_i,
  input  logic clr_i,
  output logic flag_o,
  output logic toggle_o,
  output logic pending_o
);

  localparam int CW = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES);

  logic          sync1_q;
  logic          sync2_q;
  logic          flag_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc;
  ch_state_e     state_q;
  logic          done_w;
  logic          hold_w;
  logic          toggle_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  assign cnt_inc  = cnt_q + CW'(1);
  // done_w marks the tick on which a full run of differing samples completes.
  assign done_w   = en_i && tick_i && (state_q == ST_PENDING) &&
                    (sync2_q != flag_q) && (cnt_inc == CNT_LAST);
  assign toggle_w = done_w && !hold_w;

`ifdef HAZ_LATCH_EN
  logic sticky_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (clr_i) begin
      sticky_q <= 1'b0;
    end else if (latch_i && toggle_w && !flag_q) begin
      sticky_q <= 1'b1;
    end
  end

  assign hold_w = sticky_q;
`else
  logic unused_latch;

  assign unused_latch = latch_i ^ clr_i;
  assign hold_w       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
    end else if (!en_i) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
    end else if (tick_i) begin
      case (state_q)
        ST_STABLE: begin
          if (sync2_q != flag_q) begin
            state_q <= ST_PENDING;
            cnt_q   <= CW'(1);
          end else begin
            cnt_q <= '0;
          end
        end
        ST_PENDING: begin
          if (sync2_q == flag_q) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
          end else if (cnt_inc == CNT_LAST) begin
            // A held sticky flag still returns to STABLE so the next tick re-evaluates it.
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            if (!hold_w) flag_q <= ~flag_q;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q <= ST_STABLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign flag_o    = flag_q;
  assign toggle_o  = toggle_w;
  assign pending_o = (state_q == ST_PENDING);

endmodule

// File: rtl/hazard_sensor_qualifier.sv
// Hazard sensor front-end: sample-tick prescaler, four debounced channels and a registered update pulse.
// Defining HAZ_LATCH_EN makes gas and smoke sticky until clr.
module hazard_sensor_qualifier
  import haz_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic              raw_g,
  input  logic              raw_s,
  input  logic              raw_h,
  input  logic              raw_t,
  output logic              gas,
  output logic              smoke,
  output logic              humidity,
  output logic              temperature,
  output logic              upd,
  output logic [NUM_CH-1:0] dbg_pending
);

  localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SAMPLE_DIV - 1);

  logic [PW-1:0]     pre_q;
  logic [PW-1:0]     pre_d;
  logic              tick_w;
  logic              upd_q;
  logic              upd_d;
  logic [NUM_CH-1:0] raw_w;
  logic [NUM_CH-1:0] latch_w;
  logic [NUM_CH-1:0] flag_w;
  logic [NUM_CH-1:0] toggle_w;
  logic [NUM_CH-1:0] pending_w;

  assign raw_w[CH_GAS]   = raw_g;
  assign raw_w[CH_SMOKE] = raw_s;
  assign raw_w[CH_HUM]   = raw_h;
  assign raw_w[CH_TEMP]  = raw_t;

  assign latch_w[CH_GAS]   = 1'b1;
  assign latch_w[CH_SMOKE] = 1'b1;
  assign latch_w[CH_HUM]   = 1'b0;
  assign latch_w[CH_TEMP]  = 1'b0;

  // Prescaler parks at zero while disabled so qualification restarts from a clean phase.
  always_comb begin
    pre_d = '0;
    if (en && (pre_q != PRE_LAST)) pre_d = pre_q + PW'(1);
  end

  assign tick_w = en && (pre_q == PRE_LAST);
  assign upd_d  = |toggle_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      upd_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      upd_q <= upd_d;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    hazard_debounce_ch #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw_i    (raw_w[c]),
      .en_i     (en),
      .tick_i   (tick_w),
      .latch_i  (latch_w[c]),
      .clr_i    (clr),
      .flag_o   (flag_w[c]),
      .toggle_o (toggle_w[c]),
      .pending_o(pending_w[c])
    );
  end

  assign gas         = flag_w[CH_GAS];
  assign smoke       = flag_w[CH_SMOKE];
  assign humidity    = flag_w[CH_HUM];
  assign temperature = flag_w[CH_TEMP];
  assign upd         = upd_q;
  assign dbg_pending = pending_w;

endmodule

// File: tb/tb_hazard_sensor_qualifier.sv
// Self-checking bench for hazard_sensor_qualifier (DEB_CYCLES=4; SAMPLE_DIV=1 and 3); honours HAZ_LATCH_EN.
module tb_hazard_sensor_qualifier;
  import haz_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       clr = 1'b0;
  logic       raw_g = 1'b0, raw_s = 1'b0, raw_h = 1'b0, raw_t = 1'b0;
  logic       gas, smoke, humidity, temperature, upd;
  logic [3:0] dbg_pending;
  logic       raw_h3 = 1'b0, zero3 = 1'b0;
  logic       gas3, smoke3, humidity3, temperature3, upd3;
  logic [3:0] dbg_pending3;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [3:0] raw;        // {t, h, s, g}
    int         hold;       // cycles to hold the pattern
    logic [3:0] exp_flags;  // {temperature, humidity, smoke, gas} at end of hold
    int         exp_upd;    // upd pulses seen during hold
  } vec_t;

  vec_t vecs[9];

  hazard_sensor_qualifier #(.DEB_CYCLES(4), .SAMPLE_DIV(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .raw_g(raw_g), .raw_s(raw_s), .raw_h(raw_h), .raw_t(raw_t),
    .gas(gas), .smoke(smoke), .humidity(humidity), .temperature(temperature),
    .upd(upd), .dbg_pending(dbg_pending)
  );

  hazard_sensor_qualifier #(.DEB_CYCLES(4), .SAMPLE_DIV(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .raw_g(zero3), .raw_s(zero3), .raw_h(raw_h3), .raw_t(zero3),
    .gas(gas3), .smoke(smoke3), .humidity(humidity3), .temperature(temperature3),
    .upd(upd3), .dbg_pending(dbg_pending3)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_raw(input logic [3:0] r);
    {raw_t, raw_h, raw_s, raw_g} = r;
  endtask

  function automatic logic [3:0] flags();
    return {temperature, humidity, smoke, gas};
  endfunction

  // Scoreboard
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic sb_push(input logic [3:0] f, input int u);
    exp_q.push_back({u[3:0], f});
  endtask

  task automatic sb_check(input string name, input logic [7:0] act);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got %0h with empty expected queue", name, act);
    end else begin
      chk(name, int'(act), int'(exp_q.pop_front()));
    end
  endtask

  initial begin
    int ucnt;
    int n;
    logic saw_s, saw_u;

    vecs[0] = '{4'b0000, 20, 4'b0000, 0};
    vecs[1] = '{4'b1000,  8, 4'b1000, 1};
    vecs[2] = '{4'b0100,  8, 4'b0100, 1};
    vecs[3] = '{4'b1100,  8, 4'b1100, 1};
    vecs[4] = '{4'b0000,  8, 4'b0000, 1};
    vecs[5] = '{4'b1100,  3, 4'b0000, 0};
    vecs[6] = '{4'b0000,  8, 4'b0000, 0};
    vecs[7] = '{4'b1100,  4, 4'b0000, 0};
    vecs[8] = '{4'b0000,  8, 4'b0000, 2};

    // Reset
    repeat (3) @(negedge clk);
    chk("reset_flags", int'(flags()), 0);
    chk("reset_upd", int'(upd), 0);
    rst_n = 1'b1;

    // Table of humidity/temperature patterns
    for (int v = 0; v < 9; v++) begin
      ucnt = 0;
      drive_raw(vecs[v].raw);
      sb_push(vecs[v].exp_flags, vecs[v].exp_upd);
      for (int c = 0; c < vecs[v].hold; c++) begin
        step();
        if (upd) ucnt++;
      end
      sb_check($sformatf("vec%0d", v), {ucnt[3:0], flags()});
    end

    // Exact latency of a temperature rise
    drive_raw(4'b1000);
    for (int i = 1; i <= 7; i++) begin
      step();
      chk($sformatf("seqA_temp_e%0d", i), int'(temperature), int'(i >= 6));
      chk($sformatf("seqA_upd_e%0d", i), int'(upd), int'(i == 6));
    end
    chk("seqA_others", int'({humidity, smoke, gas}), 0);

    // Asynchronous reset while gas is pending with cnt=2
    drive_raw(4'b1001);
    repeat (4) step();
    chk("seqB_pending_before", int'(dbg_pending[CH_GAS]), 1);
    chk("seqB_temp_before", int'(temperature), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("seqB_temp_in_reset", int'(temperature), 0);
    chk("seqB_gas_in_reset", int'(gas), 0);
    chk("seqB_pending_in_reset", int'(dbg_pending), 0);
    chk("seqB_upd_in_reset", int'(upd), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 5) chk("seqB_gas_e5", int'(gas), 0);
      if (i == 6) chk("seqB_gas_e6", int'(gas), 1);
    end

    // Gas fall: sticky when latched, then clr
    drive_raw(4'b1000);
    ucnt = 0;
    repeat (20) begin
      step();
      if (upd) ucnt++;
    end
`ifdef HAZ_LATCH_EN
    chk("seqC_gas_held", int'(gas), 1);
    chk("seqC_upd_held", ucnt, 0);
`else
    chk("seqC_gas_fell", int'(gas), 0);
    chk("seqC_upd_fell", ucnt, 1);
`endif
    clr = 1'b1;
    step();
    clr = 1'b0;
    n = 0;
    while (gas !== 1'b0 && n < 15) begin
      step();
      n++;
    end
    chk("seqC_gas_after_clr", int'(gas), 0);

    // Smoke pulses of 3 and 4 cycles
    drive_raw(4'b1010);
    repeat (3) step();
    drive_raw(4'b1000);
    saw_s = 1'b0;
    saw_u = 1'b0;
    repeat (12) begin
      step();
      if (smoke) saw_s = 1'b1;
      if (upd) saw_u = 1'b1;
    end
    chk("seqS_short_smoke", int'(saw_s), 0);
    chk("seqS_short_upd", int'(saw_u), 0);
    drive_raw(4'b1010);
    repeat (4) step();
    drive_raw(4'b1000);
    saw_s = 1'b0;
    repeat (15) begin
      step();
      if (smoke) saw_s = 1'b1;
    end
    chk("seqS_long_smoke_rose", int'(saw_s), 1);
`ifdef HAZ_LATCH_EN
    chk("seqS_smoke_held", int'(smoke), 1);
`else
    chk("seqS_smoke_fell", int'(smoke), 0);
`endif
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (15) step();
    chk("seqS_smoke_after_clr", int'(smoke), 0);

    // Enable gating
    en = 1'b0;
    drive_raw(4'b1100);
    ucnt = 0;
    repeat (20) begin
      step();
      if (upd) ucnt++;
    end
    chk("seqD_hum_disabled", int'(humidity), 0);
    chk("seqD_upd_disabled", ucnt, 0);
    chk("seqD_pending_disabled", int'(dbg_pending), 0);
    en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i == 3) chk("seqD_hum_e3", int'(humidity), 0);
      if (i == 4) chk("seqD_hum_e4", int'(humidity), 1);
    end

    // SAMPLE_DIV=3 latency
    raw_h3 = 1'b1;
    n = 0;
    while (humidity3 !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    chk_range("seqE_latency", n, 12, 16);
    chk("seqE_upd", int'(upd3), 1);
    chk("seqE_pending", int'(dbg_pending3), 0);
    chk("seqE_others", int'({temperature3, smoke3, gas3}), 0);

    // Report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_sensor_qualifier.md
# hazard_sensor_qualifier

Sensor front-end for the hazard indicator path. Takes four raw, asynchronous threshold bits (gas, smoke, humidity, temperature), synchronises them, debounces each on a prescaled sample tick, and drives stable gas/smoke/humidity/temperature flags. These flags feed the red/yellow/green hazard circuit, so this block is the producing end of that circuit's inputs.

## Interface
- DEB_CYCLES, 4: consecutive differing sample ticks required to accept a change; legal range 2..255.
- SAMPLE_DIV, 1: clock cycles per sample tick; legal range 1..65535.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  qualification enable.
- clr  in  1  clears latched alarms; only used when HAZ_LATCH_EN is defined.
- raw_g, raw_s, raw_h, raw_t  in  1 each  raw sensor threshold bits, asynchronous to clk.
- gas, smoke, humidity, temperature  out  1 each  qualified flags.
- upd  out  1  one-cycle pulse when any flag changes.

## Operation
- Each raw bit passes through a 2-flop synchroniser (sync1, then sync2). The synchroniser runs regardless of en.
- Prescaler counts 0..SAMPLE_DIV-1 and wraps. tick=1 when the count equals SAMPLE_DIV-1. With SAMPLE_DIV=1, tick is constantly 1.
- Each channel has a 2-state FSM and a counter cnt of width $clog2(DEB_CYCLES+1).
  - STABLE: on tick, if sync2 != flag, set cnt=1 and go to PENDING. Otherwise stay, with cnt=0.
  - PENDING: on tick, if sync2 == flag, set cnt=0 and go to STABLE (glitch rejected). Otherwise, if cnt+1 == DEB_CYCLES, toggle the flag, set cnt=0 and go to STABLE. Otherwise increment cnt.
  - No tick: hold all channel state.
- upd is registered. It is 1 for exactly the cycle following any edge on which at least one flag toggled. Simultaneous toggles on several channels produce a single pulse.
- en=0: the prescaler is held at 0, every channel is forced to STABLE with cnt=0, and flags hold their values. Qualification restarts from zero when en returns to 1.
- Reset (any time, including mid-PENDING): all flags=0, upd=0, cnt=0, prescaler=0, synchronisers=0, all FSMs in STABLE.

## Timing
- Raw change first captured by sync1 at edge k: sync2 reflects it at edge k+1.
- With SAMPLE_DIV=1, the flag toggles at edge k+DEB_CYCLES+1 and upd is high during the following cycle.
- With SAMPLE_DIV>1, latency is 2 cycles plus DEB_CYCLES ticks. Tick phase adds up to SAMPLE_DIV-1 cycles.
- A raw pulse of fewer than DEB_CYCLES ticks never changes the flag.
- No combinational path from any input to any output.

## Configuration
- HAZ_LATCH_EN defined: gas and smoke are sticky.
  - Once either flag goes to 1, the debounced 1→0 transition is suppressed; the flag holds and cnt clears.
  - clr=1 clears the sticky state. The flag then falls through normal debounce on later ticks.
  - humidity and temperature are unaffected.
- HAZ_LATCH_EN undefined: all four channels behave identically and clr is ignored.

## Structure
- Package haz_pkg:
  - channel FSM state enum {ST_STABLE, ST_PENDING}.
  - channel index constants CH_GAS=0, CH_SMOKE=1, CH_HUM=2, CH_TEMP=3.
  - default DEB_CYCLES / SAMPLE_DIV constants.
- Sub-module hazard_debounce_ch: synchroniser, FSM and cnt for one channel, plus a latch input tied per channel. Instantiated 4 times.
- The top level holds the prescaler, upd generation and the en gating.

## Test plan
All scenarios use DEB_CYCLES=4, SAMPLE_DIV=1 unless stated.
- Reset with all raw bits 0, then release → all flags 0 and upd=0 for 20 cycles.
- raw_t 0→1 held, first captured at edge 10 → temperature=1 after edge 15, upd=1 for exactly the one cycle after it, other flags stay 0.
- raw_s high for 3 cycles, then low → smoke stays 0 and upd never pulses. Repeat with a 4-cycle pulse → smoke toggles to 1.
- raw_g and raw_h rise on the same edge → both flags rise on the same edge and upd pulses once.
- rst_n asserted while raw_g is PENDING with cnt=2 → gas=0 immediately. After release with raw_g still 1 → gas=1 five edges after the first capture.
- With HAZ_LATCH_EN: raw_g 1 then 0 → gas stays 1. Pulse clr for 1 cycle → gas=0 four ticks later.
- With SAMPLE_DIV=3: raw_h rise → humidity rises within 2+4×3+2 cycles.
